fetch_stage: RTL

// - IF stage of the brisc pipeline: owns the PC, issues instruction requests to the icache,
//   and drives the IF/ID register that feeds decode (ctrl). Handles icache miss latency,

---
 rtl/brisc_pkg.sv | 36 +++
 rtl/fetch_skid_buf.sv | 38 +++
 rtl/fetch_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/brisc_pkg.sv
// Shared brisc pipeline types: widths, fetch FSM states and the IF/ID slot.
package brisc_pkg;

    localparam int                 PC_BITS    = 32;
    localparam int                 INSTR_BITS = 32;
    localparam logic [PC_BITS-1:0] RESET_PC   = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic                  valid;
        logic [INSTR_BITS-1:0] instr;
        logic [PC_BITS-1:0]    pc;
        logic [PC_BITS-1:0]    pc_next;
        logic                  xcpt;
    } if_id_t;

    // Builds a live IF/ID slot; pc_next is always derived here so it can never drift from pc.
    function automatic if_id_t make_slot(input logic [INSTR_BITS-1:0] instr,
                                         input logic [PC_BITS-1:0]    pc,
                                         input logic                  xcpt);
        if_id_t s;
        s.valid   = 1'b1;
        s.instr   = instr;
        s.pc      = pc;
        s.pc_next = pc + PC_BITS'(4);
        s.xcpt    = xcpt;
        return s;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks an icache response arriving while decode is stalled.
module fetch_skid_buf
    import brisc_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   clear_i,
    input  if_id_t data_i,
    output logic   valid_o,
    output if_id_t data_o
);

    logic   valid_q;
    if_id_t data_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            valid_q <= 1'b0;
        end else if (push_i) begin
            valid_q <= 1'b1;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    // NOTE: payload is deliberately not reset; it is only ever read while valid_q is set.
    always_ff @(posedge clk) begin
        if (push_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// brisc IF stage: owns the PC, issues icache requests and drives the IF/ID register.
module fetch_stage
    import brisc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [PC_BITS-1:0]    redirect_pc_i,
    output logic                  ic_req_valid_o,
    output logic [PC_BITS-1:0]    ic_req_addr_o,
    input  logic                  ic_resp_valid_i,
    input  logic [INSTR_BITS-1:0] ic_resp_instr_i,
    output logic                  if_id_valid_o,
    output logic [INSTR_BITS-1:0] if_id_instr_o,
    output logic [PC_BITS-1:0]    if_id_pc_o,
    output logic [PC_BITS-1:0]    if_id_pc_next_o,
    output logic                  if_id_xcpt_o
);

    fetch_state_e       state_q, state_d;
    logic [PC_BITS-1:0] pc_q, pc_d;
    logic [PC_BITS-1:0] req_pc_q, req_pc_d;
    if_id_t             if_id_q, if_id_d;
    logic               halt_pend_q, halt_pend_d;

    logic   misaligned, outstanding, resp_wait, issue;
    logic   buf_push, buf_pop, buf_valid;
    if_id_t resp_slot, buf_data;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .clear_i (redirect_i),
        .data_i  (resp_slot),
        .valid_o (buf_valid),
        .data_o  (buf_data)
    );

    always_comb begin
        misaligned  = redirect_pc_i[1:0] != 2'b00;
        resp_wait   = (state_q == WAIT) && ic_resp_valid_i;
        // A request is still in flight after this cycle unless its response lands now.
        outstanding = ((state_q == WAIT) || (state_q == DISCARD)) && !ic_resp_valid_i;
        issue       = !stall_i && !redirect_i && ((state_q == IDLE) || resp_wait);
        resp_slot   = make_slot(ic_resp_instr_i, req_pc_q, 1'b0);
        buf_push    = !redirect_i && resp_wait && stall_i;
        buf_pop     = !redirect_i && !stall_i && buf_valid;
    end

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        if_id_d     = if_id_q;
        halt_pend_d = halt_pend_q;

        if (redirect_i) begin
            pc_d        = redirect_pc_i;
            if_id_d     = misaligned ? make_slot('0, redirect_pc_i, 1'b1) : '0;
            halt_pend_d = misaligned && outstanding;
            if (outstanding) begin
                state_d = DISCARD;
            end else begin
                state_d = misaligned ? HALT : IDLE;
            end
        end else begin
            if (!stall_i) begin
                if (buf_valid) begin
                    if_id_d = buf_data;
                end else if (resp_wait) begin
                    if_id_d = resp_slot;
                end else begin
                    if_id_d = '0;
                end
            end

            if (issue) begin
                pc_d     = pc_q + PC_BITS'(4);
                req_pc_d = pc_q;
            end

            unique case (state_q)
                IDLE:    if (issue) state_d = WAIT;
                WAIT:    if (ic_resp_valid_i) state_d = issue ? WAIT : IDLE;
                DISCARD: if (ic_resp_valid_i) state_d = halt_pend_q ? HALT : IDLE;
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            if_id_q     <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            if_id_q     <= if_id_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // The request strobe is combinational so a hit can re-issue in its response cycle.
    assign ic_req_valid_o  = issue && rst_n;
    assign ic_req_addr_o   = ic_req_valid_o ? pc_q : '0;
    assign if_id_valid_o   = if_id_q.valid;
    assign if_id_instr_o   = if_id_q.instr;
    assign if_id_pc_o      = if_id_q.pc;
    assign if_id_pc_next_o = if_id_q.pc_next;
    assign if_id_xcpt_o    = if_id_q.xcpt;

endmodule
